multisim_data_downsizer: RTL and testbench
==========================================

Name: multisim_data_downsizer

Overview:
- Consumer stage placed directly downstream of the multisim DPI server stage. Takes its 64-bit data_vld/data_rdy word stream and buffers it in a small FIFO.
- Splits each 64-bit word into OUT_WIDTH-bit beats, least-significant slice first, for narrow simulated interfaces (e.g. 8/16/32-bit buses).
- Absorbs server bursts so narrow-side backpressure does not stall the DPI poll loop every cycle.

Parameters:
- OUT_WIDTH, 16, output beat width; legal values 8, 16, 32, 64.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  upstream word valid.
- in_rdy  output  1  word accepted when in_vld && in_rdy at posedge clk.
- in_data  input  64  upstream word.
- out_vld  output  1  beat valid.
- out_rdy  input  1  downstream ready; beat consumed when out_vld && out_rdy.
- out_data  output  OUT_WIDTH  current beat.
- out_last  output  1  high with the final beat of a word.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO entries held, excluding the word in the beat register.

Behaviour:
- BEATS = 64/OUT_WIDTH.
- Beat index b is a $clog2(BEATS)-bit counter; when BEATS=1 the index is a constant 0 and no counter is required.
- Reset, asynchronous on rst_n low:
  - FIFO pointers, fifo_level, beat index and word-loaded flag all cleared.
  - out_vld=0, out_last=0, out_data=0.
  - in_rdy is forced to 0 while rst_n is low.
- After reset release, in_rdy = (fifo_level != FIFO_DEPTH), derived from registered state only; it never depends on in_vld.
- Push: an in handshake at edge E writes in_data to the FIFO tail; fifo_level increments after E.
- Full FIFO: no push even if a pop happens at the same edge; there is no write-through bypass.
- Beat register has two states, IDLE (no word loaded) and SEND (word loaded).
  - IDLE -> SEND at any edge where the FIFO is non-empty: pop the head into the word register and set b=0.
  - SEND, out handshake with b<BEATS-1: b increments.
  - SEND, out handshake with b=BEATS-1:
    - FIFO non-empty: pop the next word, b=0, stay in SEND (back-to-back, no bubble).
    - FIFO empty: return to IDLE.
  - SEND, no handshake: word and b hold; out_data stays stable.
- Outputs:
  - out_vld = (state==SEND).
  - out_data = word[b*OUT_WIDTH +: OUT_WIDTH].
  - out_last = out_vld && (b==BEATS-1).
  - In IDLE, out_data=0.
- Latency: a word pushed at edge E into an empty FIFO while in IDLE is popped at E+1, so out_vld rises after E+1. Minimum latency is 2 edges.
- Simultaneous push and pop at the same edge: fifo_level is unchanged and pointers advance independently.
- Capacity: with out_rdy held low, FIFO_DEPTH+1 words are accepted in total (one in the word register, FIFO_DEPTH in the FIFO).
- Pointers wrap modulo FIFO_DEPTH. fifo_level is FIFO_DEPTH exactly when full.
- Reset asserted mid-word drops the partial word and all FIFO contents; no beat is emitted after reset is released until a new push occurs.
- in_data is stored unmodified; X on in_data while in_vld=0 must not propagate to state.
- Assertions (simulation only):
  - in_vld && !in_rdy must not change in_data until accepted.
  - fifo_level never exceeds FIFO_DEPTH.

Test Plan:
- Single word, OUT_WIDTH=16: push 64'h1122334455667788 with out_rdy=1 -> out_vld rises 2 edges after the push. Beats are 16'h7788, 16'h5566, 16'h3344, 16'h1122 on consecutive cycles, with out_last only on 16'h1122.
- Back-to-back, OUT_WIDTH=16: push 64'hA..A then 64'hB..B with out_rdy=1 -> 8 contiguous beats with no bubble between words. out_last occurs on beats 4 and 8.
- Backpressure fill, FIFO_DEPTH=4: out_rdy=0 and in_vld=1 with data 1..6 -> exactly 5 words accepted, in_rdy=0 after the 5th, fifo_level=4. Releasing out_rdy drains beats of words 1..5 in order. After the first pop from the full FIFO, in_rdy returns to 1 on the next cycle.
- Random out_rdy stall: toggle out_rdy each cycle during word 64'h0123456789ABCDEF -> out_data is stable while stalled and the beat sequence is unchanged.
- Pass-through, OUT_WIDTH=64: push 3 words -> 3 beats, each with out_last=1, out_data equal to in_data.
- Reset mid-word: assert rst_n=0 after 2 of 4 beats -> out_vld=0 and fifo_level=0 immediately. After release, no beats appear until a new word 64'h5 is pushed, which yields beats 16'h0005, 0, 0, 0.

Source files
------------

// File: rtl/multisim_data_downsizer.sv
// Buffers 64-bit words from the DPI server stage in a small FIFO and replays
// each word as OUT_WIDTH-bit beats, least-significant slice first.
module multisim_data_downsizer #(
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [63:0]                   in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BEATS = 64 / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [63:0]   word_q, word_d;

  logic full, empty, push, pop, hs, last;

  always_comb begin
    full  = (level_q == LW'(FIFO_DEPTH));
    empty = (level_q == '0);
    // in_rdy looks only at registered state, never at in_vld
    in_rdy = rst_n && !full;
    push  = in_vld && in_rdy;
    last  = (b_q == BW'(BEATS - 1));
    hs    = (state_q == ST_SEND) && out_rdy;
    // Pop when idle, or when the last beat leaves so the next word follows with no bubble
    pop   = !empty && ((state_q == ST_IDLE) || (hs && last));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    b_d      = b_q;
    word_d   = word_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      word_d   = mem_q[rd_ptr_q];
      b_d      = '0;
      state_d  = ST_SEND;
    end else if (hs) begin
      if (last) state_d = ST_IDLE;
      else      b_d     = b_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      b_q      <= '0;
      word_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      b_q      <= b_d;
      word_q   <= word_d;
    end
  end

  // Storage needs no reset: only entries behind the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_vld    = (state_q == ST_SEND);
  assign out_last   = out_vld && last;
  assign fifo_level = level_q;

  if (BEATS == 1) begin : g_pass
    assign out_data = out_vld ? word_q : '0;
  end else begin : g_split
    assign out_data = out_vld ? word_q[b_q*OUT_WIDTH +: OUT_WIDTH] : '0;
  end

  a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (in_vld && !in_rdy) |=> $stable(in_data));
  a_level_max: assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LW'(FIFO_DEPTH));
endmodule

// File: tb/tb_multisim_data_downsizer.sv
// Bench for multisim_data_downsizer: directed steps plus random traffic,
// scored against a beat queue built from each accepted word.
module tb_multisim_data_downsizer;
  logic        clk, rst_n;
  logic        in_vld, in_rdy, out_vld, out_rdy, out_last;
  logic [63:0] in_data;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic        in_vld64, in_rdy64, out_vld64, out_rdy64, out_last64;
  logic [63:0] in_data64, out_data64;
  logic [2:0]  lvl64;

  multisim_data_downsizer #(.OUT_WIDTH(16), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .fifo_level(fifo_level));

  multisim_data_downsizer #(.OUT_WIDTH(64), .FIFO_DEPTH(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld64), .in_rdy(in_rdy64), .in_data(in_data64),
    .out_vld(out_vld64), .out_rdy(out_rdy64), .out_data(out_data64), .out_last(out_last64),
    .fifo_level(lvl64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic l; } beat_t;
  beat_t q16[$];
  beat_t q64[$];
  int checks = 0, fails = 0;
  int beats16 = 0, beats64 = 0, lasts64 = 0, acc16 = 0;
  logic pend = 1'b0;
  logic stall16 = 1'b0, stall64 = 1'b0;
  logic [63:0] prev16, prev64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push16(input logic [63:0] w);
    for (int k = 0; k < 4; k++) q16.push_back('{64'(w[k*16 +: 16]), k == 3});
  endtask

  // One clock: observe handshakes at the negedge, then step past the posedge
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (stall16) begin
      chk("stall16_vld", 64'(out_vld), 64'd1);
      chk("stall16_data", 64'(out_data), prev16);
    end
    if (stall64) chk("stall64_data", out_data64, prev64);
    if (in_vld && in_rdy) begin model_push16(in_data); acc16++; end
    pend = in_vld && !in_rdy;
    if (in_vld64 && in_rdy64) q64.push_back('{in_data64, 1'b1});
    if (out_vld && out_rdy) begin
      chk("beat16_pending", 64'(q16.size() > 0), 64'd1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        chk("beat16_data", 64'(out_data), e.d);
        chk("beat16_last", 64'(out_last), 64'(e.l));
      end
      beats16++;
    end
    if (out_vld64 && out_rdy64) begin
      chk("beat64_pending", 64'(q64.size() > 0), 64'd1);
      if (q64.size() > 0) begin
        e = q64.pop_front();
        chk("beat64_data", out_data64, e.d);
      end
      beats64++;
      if (out_last64) lasts64++;
    end
    stall16 = out_vld && !out_rdy;     prev16 = 64'(out_data);
    stall64 = out_vld64 && !out_rdy64; prev64 = out_data64;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (q16.size() > 0 || q64.size() > 0); i++) cycle();
    chk("drain16_empty", 64'(q16.size()), 64'd0);
    chk("drain64_empty", 64'(q64.size()), 64'd0);
  endtask

  initial begin
    int b0, first, lastc, k, a0;
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    in_vld64 = 1'b0; in_data64 = '0; out_rdy64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_in_rdy64", 64'(in_rdy64), 64'd0);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    #2 rst_n = 1'b1;
    cycle();
    chk("idle_in_rdy", 64'(in_rdy), 64'd1);

    // Single word: out_vld two edges after the push
    out_rdy = 1'b1; in_vld = 1'b1; in_data = 64'h1122334455667788;
    cycle();
    in_vld = 1'b0; in_data = 'x;
    chk("t1_vld_after_push", 64'(out_vld), 64'd0);
    chk("t1_level_after_push", 64'(fifo_level), 64'd1);
    cycle();
    chk("t1_vld_after_pop", 64'(out_vld), 64'd1);
    chk("t1_first_beat", 64'(out_data), 64'h7788);
    chk("t1_level_after_pop", 64'(fifo_level), 64'd0);
    b0 = beats16;
    repeat (4) cycle();
    chk("t1_beats", 64'(beats16 - b0), 64'd4);
    chk("t1_idle", 64'(out_vld), 64'd0);

    // Back-to-back words: 8 contiguous beats
    in_vld = 1'b1; in_data = {16{4'hA}};
    cycle();
    in_data = {16{4'hB}};
    cycle();
    in_vld = 1'b0;
    first = -1; lastc = -1; a0 = beats16;
    for (int i = 0; i < 20; i++) begin
      b0 = beats16;
      cycle();
      if (beats16 != b0) begin
        if (first < 0) first = i;
        lastc = i;
      end
    end
    chk("t2_total", 64'(beats16 - a0), 64'd8);
    chk("t2_contiguous", 64'(lastc - first), 64'd7);

    // Backpressure fill: FIFO_DEPTH+1 words accepted
    out_rdy = 1'b0; k = 1; in_vld = 1'b1; in_data = 64'd1; a0 = acc16;
    for (int i = 0; i < 12; i++) begin
      b0 = acc16;
      cycle();
      if (acc16 != b0 && k < 6) begin k++; in_data = 64'(k); end
    end
    chk("t3_accepted", 64'(acc16 - a0), 64'd5);
    chk("t3_in_rdy_full", 64'(in_rdy), 64'd0);
    chk("t3_level_full", 64'(fifo_level), 64'd4);
    in_vld = 1'b0; out_rdy = 1'b1;
    repeat (4) cycle();
    chk("t3_level_after_pop", 64'(fifo_level), 64'd3);
    chk("t3_in_rdy_after_pop", 64'(in_rdy), 64'd1);
    drain();

    // Toggling out_rdy during one word
    out_rdy = 1'b0; in_vld = 1'b1; in_data = 64'h0123456789ABCDEF;
    cycle();
    in_vld = 1'b0; b0 = beats16;
    for (int i = 0; i < 30; i++) begin
      out_rdy = ~out_rdy;
      cycle();
    end
    chk("t4_beats", 64'(beats16 - b0), 64'd4);
    drain();

    // Pass-through width
    out_rdy64 = 1'b1; in_vld64 = 1'b1; b0 = beats64; a0 = lasts64;
    for (int i = 0; i < 3; i++) begin
      in_data64 = {$urandom, $urandom};
      cycle();
    end
    in_vld64 = 1'b0;
    repeat (6) cycle();
    chk("t5_beats64", 64'(beats64 - b0), 64'd3);
    chk("t5_lasts64", 64'(lasts64 - a0), 64'd3);

    // Reset in the middle of a word
    out_rdy = 1'b1; in_vld = 1'b1; in_data = 64'hDEADBEEFCAFEF00D;
    cycle();
    in_vld = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(out_vld), 64'd0);
    chk("t6_rst_level", 64'(fifo_level), 64'd0);
    chk("t6_rst_in_rdy", 64'(in_rdy), 64'd0);
    q16.delete(); stall16 = 1'b0;
    #2 rst_n = 1'b1;
    b0 = beats16;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t6_quiet_vld", 64'(out_vld), 64'd0);
    end
    chk("t6_quiet_beats", 64'(beats16 - b0), 64'd0);
    in_vld = 1'b1; in_data = 64'h5;
    cycle();
    in_vld = 1'b0;
    drain();

    // Random traffic on the narrow instance
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        in_vld  = ($urandom_range(0, 1) == 1);
        in_data = {$urandom, $urandom};
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      cycle();
      chk("rnd_in_rdy_rule", 64'(in_rdy), 64'(fifo_level != 3'd4));
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
